collision_scheduler: RTL and testbench

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

---
 rtl/collision_scheduler.sv | 152 +++++++++++++++
 tb/tb_collision_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Collision pair scheduler.
// On a frame tick it walks every unordered entity pair (i<j) in order. Each pair is offered to
// a shared overlap checker, and the per-pair overlap results are collected into a hit mask and
// a hit count.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   frame_tick, enable        - sweep request pulse; request is ignored when enable is low
//   pair_valid/pair_i/pair_j  - pair offered to the checker, held until pair_ready
//   pair_ready                - checker accepts the offered pair
//   result_valid/result_hit   - checker result for the accepted pair
//   hit_mask, hit_count       - per-pair results of current/most recent sweep, and their popcount
//   busy, sweep_done          - sweep in progress; one-cycle completion pulse
//   overrun_cnt               - saturating count of ticks dropped while busy
//   timeout_err               - sticky: some pair got no result within WAIT_TIMEOUT cycles
module collision_scheduler #(
    parameter int unsigned N            = 8,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic                   enable,
    output logic                   pair_valid,
    output logic [2:0]             pair_i,
    output logic [2:0]             pair_j,
    input  logic                   pair_ready,
    input  logic                   result_valid,
    input  logic                   result_hit,
    output logic [N*(N-1)/2-1:0]   hit_mask,
    output logic [4:0]             hit_count,
    output logic                   busy,
    output logic                   sweep_done,
    output logic [7:0]             overrun_cnt,
    output logic                   timeout_err
);

    localparam int unsigned NP = N * (N - 1) / 2;
    localparam int unsigned KW = (NP > 1) ? $clog2(NP) : 1;
    localparam int unsigned WW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          state_q;
    logic            pair_valid_q;
    logic [2:0]      pair_i_q, pair_j_q;
    logic [KW-1:0]   k_q;
    logic [WW-1:0]   wait_cnt_q;
    logic [NP-1:0]   hit_mask_q;
    logic [4:0]      hit_count_q;
    logic            busy_q, sweep_done_q, timeout_err_q;
    logic [7:0]      overrun_q;

    logic [2:0]      pair_i_d, pair_j_d;
    logic            last_pair, wait_expired;

    // Next pair in row-major upper-triangle order.
    always_comb begin
        pair_i_d = pair_i_q;
        pair_j_d = pair_j_q + 3'd1;
        if (pair_j_q == 3'(N - 1)) begin
            pair_i_d = pair_i_q + 3'd1;
            pair_j_d = pair_i_q + 3'd2;
        end
    end

    assign last_pair    = (k_q == KW'(NP - 1));
    assign wait_expired = (wait_cnt_q == WW'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pair_valid_q  <= 1'b0;
            pair_i_q      <= 3'd0;
            pair_j_q      <= 3'd1;
            k_q           <= '0;
            wait_cnt_q    <= '0;
            hit_mask_q    <= '0;
            hit_count_q   <= 5'd0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            overrun_q     <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            // Ticks while busy are counted, never queued.
            if (frame_tick && state_q != StIdle && overrun_q != 8'hFF) begin
                overrun_q <= overrun_q + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (frame_tick && enable) begin
                        state_q      <= StIssue;
                        busy_q       <= 1'b1;
                        pair_valid_q <= 1'b1;
                        pair_i_q     <= 3'd0;
                        pair_j_q     <= 3'd1;
                        k_q          <= '0;
                        hit_mask_q   <= '0;
                        hit_count_q  <= 5'd0;
                    end
                end
                StIssue: begin
                    if (pair_ready) begin
                        state_q      <= StWait;
                        pair_valid_q <= 1'b0;
                        wait_cnt_q   <= '0;
                    end
                end
                StWait: begin
                    if (result_valid || wait_expired) begin
                        // A timed-out pair records no hit.
                        hit_mask_q[k_q] <= result_valid & result_hit;
                        if (result_valid) begin
                            hit_count_q <= hit_count_q + {4'd0, result_hit};
                        end else begin
                            timeout_err_q <= 1'b1;
                        end
                        if (last_pair) begin
                            state_q      <= StDone;
                            sweep_done_q <= 1'b1;
                        end else begin
                            state_q      <= StIssue;
                            pair_valid_q <= 1'b1;
                            pair_i_q     <= pair_i_d;
                            pair_j_q     <= pair_j_d;
                            k_q          <= k_q + KW'(1);
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pair_valid  = pair_valid_q;
    assign pair_i      = pair_i_q;
    assign pair_j      = pair_j_q;
    assign hit_mask    = hit_mask_q;
    assign hit_count   = hit_count_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign overrun_cnt = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Self-checking bench for collision_scheduler (default N=8, WAIT_TIMEOUT=15).
// Expected pair order is pushed to a scoreboard queue before each sweep and popped
// as each handshake is observed; hit masks, counts and latencies come from bench-side models.
module tb_collision_scheduler;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        enable;
    logic        pair_valid;
    logic [2:0]  pair_i;
    logic [2:0]  pair_j;
    logic        pair_ready;
    logic        result_valid;
    logic        result_hit;
    logic [27:0] hit_mask;
    logic [4:0]  hit_count;
    logic        busy;
    logic        sweep_done;
    logic [7:0]  overrun_cnt;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];

    collision_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .enable      (enable),
        .pair_valid  (pair_valid),
        .pair_i      (pair_i),
        .pair_j      (pair_j),
        .pair_ready  (pair_ready),
        .result_valid(result_valid),
        .result_hit  (result_hit),
        .hit_mask    (hit_mask),
        .hit_count   (hit_count),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_order();
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                exp_q.push_back({3'(i), 3'(j)});
            end
        end
    endtask

    function automatic int popcount28(input logic [27:0] v);
        int n = 0;
        for (int b = 0; b < 28; b++) n += int'(v[b]);
        return n;
    endfunction

    // Drives one sweep and answers the checker side. Latency is counted in cycles from the
    // tick cycle to the sweep_done cycle (-1 if sweep_done never arrives).
    task automatic run_sweep(input logic [27:0] hits, input int stall_k, input int stall_n,
                             input int to_k, input int n_extra, input bit drop_en,
                             output int lat, output int hs, output int stalls,
                             output int unstable);
        int cyc;
        int last_k;
        bit have;
        logic [2:0] si, sj;
        logic [5:0] e;
        lat = -1; hs = 0; stalls = 0; unstable = 0; last_k = -1; have = 0;
        si = 3'd0; sj = 3'd0;
        @(negedge clk);
        frame_tick = 1'b1; enable = 1'b1; pair_ready = 1'b1;
        result_valid = 1'b1; result_hit = 1'b0;
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            frame_tick = (cyc >= 2 && cyc < 2 + n_extra);
            if (drop_en && cyc >= 3) enable = 1'b0;
            if (sweep_done) begin
                lat = cyc;
                break;
            end
            pair_ready = 1'b1;
            if (pair_valid) begin
                if (hs == stall_k && stalls < stall_n) begin
                    if (!have) begin
                        si = pair_i; sj = pair_j; have = 1;
                    end else if (pair_i !== si || pair_j !== sj) begin
                        unstable++;
                    end
                    pair_ready = 1'b0;
                    stalls++;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pair_order: got (%0d,%0d) required no further pair",
                                 pair_i, pair_j);
                    end else begin
                        e = exp_q.pop_front();
                        if ({pair_i, pair_j} !== e) begin
                            errors++;
                            $display("FAIL pair_order[%0d]: got (%0d,%0d) required (%0d,%0d)",
                                     hs, pair_i, pair_j, e[5:3], e[2:0]);
                        end
                    end
                    last_k = hs;
                    hs++;
                end
            end
            result_valid = (last_k != to_k);
            result_hit   = (last_k >= 0) ? hits[last_k] : 1'b0;
        end
        frame_tick = 1'b0; enable = 1'b1; pair_ready = 1'b1; result_valid = 1'b0;
        result_hit = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({pair_valid, pair_i, pair_j, busy, sweep_done} !== {1'b0, 3'd0, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b i=%0d j=%0d busy=%b done=%b required 0 0 1 0 0",
                     pair_valid, pair_i, pair_j, busy, sweep_done);
        end
        checks++;
        if (hit_mask !== 28'd0 || hit_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_hits: got mask=%h count=%0d required 0 0", hit_mask, hit_count);
        end
        checks++;
        if (overrun_cnt !== 8'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got ovr=%0d to=%b required 0 0", overrun_cnt, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pair_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b valid=%b required 0 0", busy, pair_valid);
        end
    endtask

    task automatic test_basic();
        int lat, hs, st, un;
        push_order();
        run_sweep(28'd0, -1, 0, -1, 0, 0, lat, hs, st, un);
        checks++;
        if (lat !== 57) begin
            errors++; $display("FAIL basic_latency: got %0d required 57", lat);
        end
        checks++;
        if (hs !== 28 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_handshakes: got %0d left=%0d required 28 left=0", hs, exp_q.size());
        end
        checks++;
        if (hit_mask !== 28'd0 || hit_count !== 5'd0) begin
            errors++;
            $display("FAIL basic_hits: got mask=%h count=%0d required 0 0", hit_mask, hit_count);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sweep_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b done=%b required 0 0", busy, sweep_done);
        end
    endtask

    task automatic test_hits();
        int lat, hs, st, un;
        logic [27:0] hits;
        hits = 28'd0;
        hits[0] = 1'b1;   // (0,1)
        hits[27] = 1'b1;  // (6,7)
        exp_q.delete();
        push_order();
        run_sweep(hits, -1, 0, -1, 0, 0, lat, hs, st, un);
        checks++;
        if (hit_mask !== 28'h8000001 || hit_count !== 5'(popcount28(hits))) begin
            errors++;
            $display("FAIL hits_mask: got mask=%h count=%0d required 8000001 %0d",
                     hit_mask, hit_count, popcount28(hits));
        end
        // Tick with enable low and stray results in IDLE must change nothing.
        @(negedge clk);
        frame_tick = 1'b1; enable = 1'b0; result_valid = 1'b1; result_hit = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        result_valid = 1'b0; result_hit = 1'b0;
        checks++;
        if (busy !== 1'b0 || pair_valid !== 1'b0) begin
            errors++;
            $display("FAIL disabled_tick: got busy=%b valid=%b required 0 0", busy, pair_valid);
        end
        checks++;
        if (hit_mask !== 28'h8000001 || hit_count !== 5'd2) begin
            errors++;
            $display("FAIL idle_hold: got mask=%h count=%0d required 8000001 2",
                     hit_mask, hit_count);
        end
    endtask

    task automatic test_stall();
        int lat, hs, st, un;
        exp_q.delete();
        push_order();
        run_sweep(28'd0, 14, 10, -1, 0, 0, lat, hs, st, un);  // k=14 is (2,5)
        checks++;
        if (st !== 10 || un !== 0) begin
            errors++;
            $display("FAIL stall_hold: got stalls=%0d unstable=%0d required 10 0", st, un);
        end
        checks++;
        if (lat !== 67 || hs !== 28) begin
            errors++;
            $display("FAIL stall_latency: got lat=%0d hs=%0d required 67 28", lat, hs);
        end
    endtask

    task automatic test_timeout();
        int lat, hs, st, un;
        logic [27:0] hits, expm;
        hits = 28'hFFFFFFF;
        expm = hits;
        expm[8] = 1'b0;  // (1,3) never answered
        exp_q.delete();
        push_order();
        run_sweep(hits, -1, 0, 8, 0, 0, lat, hs, st, un);
        checks++;
        if (lat !== 71 || hs !== 28) begin
            errors++;
            $display("FAIL timeout_latency: got lat=%0d hs=%0d required 71 28", lat, hs);
        end
        checks++;
        if (hit_mask !== expm || hit_count !== 5'(popcount28(expm))) begin
            errors++;
            $display("FAIL timeout_mask: got mask=%h count=%0d required %h %0d",
                     hit_mask, hit_count, expm, popcount28(expm));
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_flag: got %b required 1", timeout_err);
        end
    endtask

    task automatic test_overrun();
        int lat, hs, st, un;
        exp_q.delete();
        push_order();
        // Enable also drops mid-sweep here; the sweep must still finish.
        run_sweep(28'd0, -1, 0, -1, 3, 1, lat, hs, st, un);
        checks++;
        if (overrun_cnt !== 8'd3) begin
            errors++; $display("FAIL overrun_three: got %0d required 3", overrun_cnt);
        end
        checks++;
        if (lat !== 57 || hs !== 28) begin
            errors++;
            $display("FAIL enable_drop: got lat=%0d hs=%0d required 57 28", lat, hs);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b required 1", timeout_err);
        end
        exp_q.delete();
        push_order();
        run_sweep(28'd0, 0, 350, -1, 300, 0, lat, hs, st, un);
        checks++;
        if (overrun_cnt !== 8'd255) begin
            errors++; $display("FAIL overrun_sat: got %0d required 255", overrun_cnt);
        end
        checks++;
        if (lat !== 407) begin
            errors++; $display("FAIL overrun_latency: got %0d required 407", lat);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pair_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_queued_sweep: got busy=%b valid=%b required 0 0", busy, pair_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat, hs, st, un;
        @(negedge clk);
        frame_tick = 1'b1; enable = 1'b1; pair_ready = 1'b1; result_valid = 1'b0;
        @(negedge clk);  // ISSUE
        frame_tick = 1'b0;
        @(negedge clk);  // WAIT
        @(negedge clk);  // WAIT
        checks++;
        if (busy !== 1'b1 || pair_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_wait: got busy=%b valid=%b required 1 0", busy, pair_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pair_valid, pair_i, pair_j, busy, sweep_done} !== {1'b0, 3'd0, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_ctrl: got v=%b i=%0d j=%0d busy=%b done=%b required 0 0 1 0 0",
                     pair_valid, pair_i, pair_j, busy, sweep_done);
        end
        checks++;
        if (hit_mask !== 28'd0 || hit_count !== 5'd0 || overrun_cnt !== 8'd0
            || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got mask=%h cnt=%0d ovr=%0d to=%b required 0 0 0 0",
                     hit_mask, hit_count, overrun_cnt, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        push_order();
        run_sweep(28'd0, -1, 0, -1, 0, 0, lat, hs, st, un);
        checks++;
        if (lat !== 57 || hs !== 28 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_sweep: got lat=%0d hs=%0d required 57 28", lat, hs);
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; pair_ready = 1'b0;
        result_valid = 1'b0; result_hit = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_hits();
        test_stall();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
